// File: rtl/wb_snoop_initiator.sv
// wb_snoop_initiator
// Initiator side of the per-core snoop interface. Every granted data-bus beat
// is snooped in all cores except its requester. Reads that hit in a peer are
// answered with the snooped data, and everything else goes to memory as a
// classic single transfer.
// Optional build macro: WB_SNOOP_INITIATOR_STATS_EN adds the saturating
// stat_snoops_o / stat_hits_o counters.
module wb_snoop_initiator #(
  parameter int NUM_CORES     = 2,
  parameter int ID_WIDTH      = 2,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [31:0]               m_adr_i,
  input  logic [31:0]               m_dat_i,
  input  logic [3:0]                m_sel_i,
  input  logic                      m_we_i,
  input  logic                      m_cyc_i,
  input  logic                      m_stb_i,
  input  logic [2:0]                m_cti_i,
  input  logic [1:0]                m_bte_i,
  input  logic [ID_WIDTH-1:0]       m_id_i,
  output logic [31:0]               m_dat_o,
  output logic                      m_ack_o,
  output logic                      m_err_o,
  output logic                      m_rty_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [32*NUM_CORES-1:0]   snoop_adr_o,
  output logic [NUM_CORES-1:0]      snoop_req_o,
  input  logic [NUM_CORES-1:0]      snoop_ack_i,
  input  logic [NUM_CORES-1:0]      snoop_hit_i,
  input  logic [32*NUM_CORES-1:0]   snoop_dat_i
`ifdef WB_SNOOP_INITIATOR_STATS_EN
  ,
  output logic [31:0]               stat_snoops_o,
  output logic [31:0]               stat_hits_o
`endif
);

  localparam int TW = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(SNOOP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_MEM   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [31:0]          adr_r, adr_s;
  logic [31:0]          dat_r, dat_s;
  logic [3:0]           sel_r, sel_s;
  logic                 we_r, we_s;
  logic [NUM_CORES-1:0] pending_r, pending_s;
  logic [NUM_CORES-1:0] pend_init_s, ack_s, hit_vec_s;
  logic                 hit_r, hit_s;
  logic [31:0]          hit_dat_r, hit_dat_s, first_hit_dat_s;
  logic [TW-1:0]        tmo_r, tmo_s;
  logic [31:0]          m_dat_r, m_dat_s;
  logic                 m_ack_r, m_ack_s;
  logic                 m_err_r, m_err_s;
  logic                 m_rty_r, m_rty_s;
  logic                 s_cyc_r, s_cyc_s;

  // Cycle type and burst type are not used: every beat is handled on its own.
  logic unused_s;
  assign unused_s = ^{m_cti_i, m_bte_i};

  // Next-state and next-output logic for the beat sequencer.
  always_comb begin
    state_s   = state_r;
    adr_s     = adr_r;
    dat_s     = dat_r;
    sel_s     = sel_r;
    we_s      = we_r;
    pending_s = pending_r;
    hit_s     = hit_r;
    hit_dat_s = hit_dat_r;
    tmo_s     = tmo_r;
    m_dat_s   = m_dat_r;
    m_ack_s   = 1'b0;
    m_err_s   = 1'b0;
    m_rty_s   = 1'b0;
    s_cyc_s   = s_cyc_r;

    // A core master is never snooped in its own cache. A non-core id snoops every core.
    pend_init_s = {NUM_CORES{1'b1}};
    for (int k = 0; k < NUM_CORES; k++) begin
      if (32'(m_id_i) == 32'(k)) begin
        pend_init_s[k] = 1'b0;
      end else begin
        pend_init_s[k] = 1'b1;
      end
    end

    // Only acks on outstanding requests count. Among same-cycle hits the lowest index wins.
    ack_s           = snoop_ack_i & pending_r;
    hit_vec_s       = ack_s & snoop_hit_i;
    first_hit_dat_s = hit_dat_r;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      first_hit_dat_s = hit_vec_s[k] ? snoop_dat_i[32*k +: 32] : first_hit_dat_s;
    end

    case (state_r)
      ST_IDLE: begin
        tmo_s = '0;
        hit_s = 1'b0;
        if (m_cyc_i && m_stb_i) begin
          adr_s     = m_adr_i;
          dat_s     = m_dat_i;
          sel_s     = m_sel_i;
          we_s      = m_we_i;
          pending_s = pend_init_s;
          if (pend_init_s != {NUM_CORES{1'b0}}) begin
            state_s = ST_SNOOP;
          end else begin
            state_s = ST_MEM;
            s_cyc_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SNOOP: begin
        if (!m_cyc_i) begin
          // Master abandoned the cycle: withdraw all requests, no response.
          pending_s = {NUM_CORES{1'b0}};
          state_s   = ST_IDLE;
        end else begin
          // An earlier captured hit keeps its data. Later hits only confirm the flag.
          if (!hit_r && (hit_vec_s != {NUM_CORES{1'b0}})) begin
            hit_s     = 1'b1;
            hit_dat_s = first_hit_dat_s;
          end else begin
            hit_s     = hit_r;
            hit_dat_s = hit_dat_r;
          end
          pending_s = pending_r & ~ack_s;
          tmo_s     = tmo_r + TW'(1);
          if (pending_s == {NUM_CORES{1'b0}}) begin
            if (!we_r && hit_s) begin
              state_s = ST_RESP;
            end else begin
              state_s = ST_MEM;
              s_cyc_s = 1'b1;
            end
          end else if (tmo_r == TMO_LAST) begin
            m_err_s   = 1'b1;
            pending_s = {NUM_CORES{1'b0}};
            state_s   = ST_IDLE;
          end else begin
            state_s = ST_SNOOP;
          end
        end
      end

      ST_MEM: begin
        if (!m_cyc_i) begin
          s_cyc_s = 1'b0;
          state_s = ST_IDLE;
        end else if (s_ack_i) begin
          m_ack_s = 1'b1;
          m_dat_s = s_dat_i;
          s_cyc_s = 1'b0;
          state_s = ST_IDLE;
        end else if (s_err_i) begin
          m_err_s = 1'b1;
          m_dat_s = s_dat_i;
          s_cyc_s = 1'b0;
          state_s = ST_IDLE;
        end else if (s_rty_i) begin
          m_rty_s = 1'b1;
          m_dat_s = s_dat_i;
          s_cyc_s = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MEM;
        end
      end

      ST_RESP: begin
        m_ack_s = 1'b1;
        m_dat_s = hit_dat_r;
        state_s = ST_IDLE;
      end

      default: begin
        pending_s = {NUM_CORES{1'b0}};
        s_cyc_s   = 1'b0;
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State, latched beat fields and registered outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r   <= ST_IDLE;
      adr_r     <= 32'h0000_0000;
      dat_r     <= 32'h0000_0000;
      sel_r     <= 4'h0;
      we_r      <= 1'b0;
      pending_r <= {NUM_CORES{1'b0}};
      hit_r     <= 1'b0;
      hit_dat_r <= 32'h0000_0000;
      tmo_r     <= '0;
      m_dat_r   <= 32'h0000_0000;
      m_ack_r   <= 1'b0;
      m_err_r   <= 1'b0;
      m_rty_r   <= 1'b0;
      s_cyc_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      adr_r     <= adr_s;
      dat_r     <= dat_s;
      sel_r     <= sel_s;
      we_r      <= we_s;
      pending_r <= pending_s;
      hit_r     <= hit_s;
      hit_dat_r <= hit_dat_s;
      tmo_r     <= tmo_s;
      m_dat_r   <= m_dat_s;
      m_ack_r   <= m_ack_s;
      m_err_r   <= m_err_s;
      m_rty_r   <= m_rty_s;
      s_cyc_r   <= s_cyc_s;
    end
  end

  assign m_dat_o     = m_dat_r;
  assign m_ack_o     = m_ack_r;
  assign m_err_o     = m_err_r;
  assign m_rty_o     = m_rty_r;
  assign s_adr_o     = adr_r;
  assign s_dat_o     = dat_r;
  assign s_sel_o     = sel_r;
  assign s_we_o      = we_r;
  assign s_cyc_o     = s_cyc_r;
  assign s_stb_o     = s_cyc_r;
  assign s_cti_o     = s_cyc_r ? 3'b111 : 3'b000;
  assign s_bte_o     = 2'b00;
  assign snoop_req_o = pending_r;
  assign snoop_adr_o = {NUM_CORES{{adr_r[31:2], 2'b00}}};

`ifdef WB_SNOOP_INITIATOR_STATS_EN
  logic [31:0] stat_snoops_r;
  logic [31:0] stat_hits_r;

  // Saturating counters: snoop broadcasts started and reads answered from a peer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stat_snoops_r <= 32'h0000_0000;
      stat_hits_r   <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_IDLE) && (state_s == ST_SNOOP) && (stat_snoops_r != 32'hFFFF_FFFF)) begin
        stat_snoops_r <= stat_snoops_r + 32'd1;
      end
      if ((state_r == ST_RESP) && (stat_hits_r != 32'hFFFF_FFFF)) begin
        stat_hits_r <= stat_hits_r + 32'd1;
      end
    end
  end

  assign stat_snoops_o = stat_snoops_r;
  assign stat_hits_o   = stat_hits_r;
`endif

endmodule

// File: tb/tb_wb_snoop_initiator.sv
// Directed scoreboard bench for wb_snoop_initiator (NUM_CORES=2, ID_WIDTH=2, SNOOP_TIMEOUT=16).
module tb_wb_snoop_initiator;
  localparam int NC  = 2;
  localparam int IW  = 2;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       m_adr_i, m_dat_i;
  logic [3:0]        m_sel_i;
  logic              m_we_i, m_cyc_i, m_stb_i;
  logic [2:0]        m_cti_i;
  logic [1:0]        m_bte_i;
  logic [IW-1:0]     m_id_i;
  logic [31:0]       m_dat_o;
  logic              m_ack_o, m_err_o, m_rty_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [32*NC-1:0]  snoop_adr_o;
  logic [NC-1:0]     snoop_req_o, snoop_ack_i, snoop_hit_i;
  logic [32*NC-1:0]  snoop_dat_i;
`ifdef WB_SNOOP_INITIATOR_STATS_EN
  logic [31:0]       stat_snoops_o, stat_hits_o;
`endif

  always #5 clk = ~clk;

  wb_snoop_initiator #(.NUM_CORES(NC), .ID_WIDTH(IW), .SNOOP_TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_id_i(m_id_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .m_rty_o(m_rty_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o),
    .s_bte_o(s_bte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .snoop_adr_o(snoop_adr_o), .snoop_req_o(snoop_req_o),
    .snoop_ack_i(snoop_ack_i), .snoop_hit_i(snoop_hit_i), .snoop_dat_i(snoop_dat_i)
`ifdef WB_SNOOP_INITIATOR_STATS_EN
    , .stat_snoops_o(stat_snoops_o), .stat_hits_o(stat_hits_o)
`endif
  );

  // Response kinds: 1 ack, 2 err, 3 rty.
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] dat;
    bit          chk_dat;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          core_dly [NC];
  logic        core_hit [NC];
  logic [31:0] core_dat [NC];
  int          core_cnt [NC];
  int          mem_lat;
  logic [1:0]  mem_kind;
  logic [31:0] mem_rdat;
  int          mem_cnt;
  int          mem_acc = 0;
  logic [31:0] mem_adr_seen, mem_wdat_seen;
  logic [3:0]  mem_sel_seen;
  logic        mem_we_seen;
  logic [2:0]  mem_cti_seen;
  logic [NC-1:0] req_or;
  logic [31:0] snoop_adr1_seen;
  bit          adr_cap;
  int          beat_tick;
  int          resp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then update the core and memory models.
  task automatic tick();
    logic [1:0] k_s;
    @(posedge clk);
    #1;
    beat_tick++;
    k_s = m_ack_o ? 2'd1 : (m_err_o ? 2'd2 : (m_rty_o ? 2'd3 : 2'd0));
    if (k_s != 2'd0) begin
      resp_cnt++;
      check("resp_onehot", 32'(m_ack_o) + 32'(m_err_o) + 32'(m_rty_o), 32'd1);
      if (sb.size() == 0) begin
        check("spurious_resp", 32'(k_s), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_kind", 32'(k_s), 32'(e.kind));
        if (e.chk_dat) check("resp_dat", m_dat_o, e.dat);
        if (e.lat >= 0) check("resp_lat", beat_tick, e.lat);
      end
      m_cyc_i = 1'b0;
      m_stb_i = 1'b0;
    end
    req_or = req_or | snoop_req_o;
    if (snoop_req_o[1] && !adr_cap) begin
      snoop_adr1_seen = snoop_adr_o[63:32];
      adr_cap = 1'b1;
    end
    for (int k = 0; k < NC; k++) begin
      if (snoop_req_o[k]) core_cnt[k]++;
      else core_cnt[k] = 0;
      if (snoop_req_o[k] && core_cnt[k] == core_dly[k]) begin
        snoop_ack_i[k] = 1'b1;
        snoop_hit_i[k] = core_hit[k];
        snoop_dat_i[32*k +: 32] = core_dat[k];
      end else begin
        snoop_ack_i[k] = 1'b0;
        snoop_hit_i[k] = 1'b0;
        snoop_dat_i[32*k +: 32] = 32'h0;
      end
    end
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'h0;
    if (s_cyc_o && s_stb_o) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        s_ack_i = (mem_kind == 2'd1);
        s_err_i = (mem_kind == 2'd2);
        s_rty_i = (mem_kind == 2'd3);
        s_dat_i = mem_rdat;
        mem_adr_seen  = s_adr_o;
        mem_wdat_seen = s_dat_o;
        mem_sel_seen  = s_sel_o;
        mem_we_seen   = s_we_o;
        mem_cti_seen  = s_cti_o;
        mem_acc++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic start_beat(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input logic [IW-1:0] id);
    req_or = '0; adr_cap = 1'b0; beat_tick = 0;
    m_adr_i = adr; m_dat_i = dat; m_sel_i = sel; m_we_i = we; m_id_i = id;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
  endtask

  // Issue a beat with its expected response queued, wait (bounded) for it, then check the pulse ends.
  task automatic run_beat(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, input logic [IW-1:0] id, input logic [1:0] kind,
                          input logic [31:0] edat, input bit chk, input int lat);
    int n0;
    n0 = resp_cnt;
    sb.push_back('{kind, edat, chk, lat});
    start_beat(adr, dat, sel, we, id);
    for (int i = 0; i < 40 && resp_cnt == n0; i++) tick();
    check("resp_seen", resp_cnt - n0, 32'd1);
    if (resp_cnt == n0) begin
      sb.delete();
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
    end
    tick();
    check("pulse_end", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0;
    m_adr_i = 32'h0; m_dat_i = 32'h0; m_sel_i = 4'h0; m_we_i = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_cti_i = 3'b000; m_bte_i = 2'b00; m_id_i = '0;
    s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    snoop_ack_i = '0; snoop_hit_i = '0; snoop_dat_i = '0;
    core_dly = '{-1, -1}; core_hit = '{1'b0, 1'b0}; core_dat = '{32'h0, 32'h0};
    core_cnt = '{0, 0};
    mem_lat = 1; mem_kind = 2'd1; mem_rdat = 32'h0; mem_cnt = 0;
    req_or = '0; adr_cap = 1'b0; beat_tick = 0;

    // Reset state.
    #12;
    check("rst_m_ack", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
    check("rst_m_dat", m_dat_o, 32'd0);
    check("rst_s_cyc", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    check("rst_s_cti", 32'(s_cti_o), 32'd0);
    check("rst_s_adr", s_adr_o, 32'd0);
    check("rst_snoop_req", 32'(snoop_req_o), 32'd0);
    check("rst_snoop_adr", snoop_adr_o[63:32], 32'd0);
    #1 rst_n = 1'b1;
    tick(); tick();

    // Core 0 reads 0x1004, core 1 misses after 2 cycles, memory answers.
    core_dly = '{-1, 2}; core_hit = '{1'b0, 1'b0}; core_dat = '{32'h0, 32'h1111_1111};
    mem_lat = 2; mem_kind = 2'd1; mem_rdat = 32'hDEAD_BEEF;
    a0 = mem_acc;
    run_beat(32'h0000_1004, 32'h0, 4'hF, 1'b0, 2'd0, 2'd1, 32'hDEAD_BEEF, 1'b1, 5);
    check("t1_req_mask", 32'(req_or), 32'h2);
    check("t1_snoop_adr", snoop_adr1_seen, 32'h0000_1004);
    check("t1_mem_acc", mem_acc - a0, 32'd1);
    check("t1_cti", 32'(mem_cti_seen), 32'h7);
    check("t1_mem_adr", mem_adr_seen, 32'h0000_1004);

    // Core 0 reads 0x2000, core 1 hits: answered without memory.
    core_dly = '{-1, 1}; core_hit = '{1'b0, 1'b1}; core_dat = '{32'h0, 32'hCAFE_F00D};
    mem_rdat = 32'h9999_9999;
    a0 = mem_acc;
    run_beat(32'h0000_2000, 32'h0, 4'hF, 1'b0, 2'd0, 2'd1, 32'hCAFE_F00D, 1'b1, 3);
    check("t2_no_mem", mem_acc - a0, 32'd0);

    // Debug id 2 writes 0x3000, both cores hit together: write still goes to memory.
    core_dly = '{1, 1}; core_hit = '{1'b1, 1'b1}; core_dat = '{32'h0A0A_0A0A, 32'h0B0B_0B0B};
    mem_lat = 1; mem_rdat = 32'hA5A5_A5A5;
    a0 = mem_acc;
    run_beat(32'h0000_3000, 32'h1234_5678, 4'b0110, 1'b1, 2'd2, 2'd1, 32'hA5A5_A5A5, 1'b1, 3);
    check("t3_req_mask", 32'(req_or), 32'h3);
    check("t3_mem_acc", mem_acc - a0, 32'd1);
    check("t3_mem_adr", mem_adr_seen, 32'h0000_3000);
    check("t3_mem_sel", 32'(mem_sel_seen), 32'h6);
    check("t3_mem_we", 32'(mem_we_seen), 32'd1);
    check("t3_mem_wdat", mem_wdat_seen, 32'h1234_5678);

    // Debug id 2 reads, both hit the same cycle: lowest index supplies data.
    a0 = mem_acc;
    run_beat(32'h0000_3004, 32'h0, 4'hF, 1'b0, 2'd2, 2'd1, 32'h0A0A_0A0A, 1'b1, 3);
    check("t4_no_mem", mem_acc - a0, 32'd0);

    // Id 3 reads 0x2003: core 1 hits first, core 0 hits later; the first capture wins.
    core_dly = '{3, 1}; core_hit = '{1'b1, 1'b1}; core_dat = '{32'hAAAA_0000, 32'hBBBB_0001};
    run_beat(32'h0000_2003, 32'h0, 4'hF, 1'b0, 2'd3, 2'd1, 32'hBBBB_0001, 1'b1, 5);
    check("t5_snoop_adr_align", snoop_adr1_seen, 32'h0000_2000);

    // Core 1 never answers: error after SNOOP_TIMEOUT snoop cycles, m_dat holds.
    core_dly = '{-1, -1};
    a0 = mem_acc;
    run_beat(32'h0000_4000, 32'h0, 4'hF, 1'b0, 2'd0, 2'd2, 32'hBBBB_0001, 1'b1, TMO + 1);
    check("t6_req_clear", 32'(snoop_req_o), 32'd0);
    check("t6_no_mem", mem_acc - a0, 32'd0);

    // Memory retry is forwarded.
    core_dly = '{-1, 1}; core_hit = '{1'b0, 1'b0}; core_dat = '{32'h0, 32'h7777_7777};
    mem_lat = 1; mem_kind = 2'd3; mem_rdat = 32'h0BAD_F00D;
    run_beat(32'h0000_5000, 32'h0, 4'hF, 1'b0, 2'd0, 2'd3, 32'h0, 1'b0, 3);
    mem_kind = 2'd1;

    // Master drops cyc during SNOOP.
    core_dly = '{-1, -1};
    n0 = resp_cnt; a0 = mem_acc;
    start_beat(32'h0000_6000, 32'h0, 4'hF, 1'b0, 2'd0);
    tick(); tick(); tick();
    check("ab_snoop_req_before", 32'(snoop_req_o), 32'h2);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    tick();
    check("ab_snoop_req_drop", 32'(snoop_req_o), 32'd0);
    repeat (3) tick();
    check("ab_snoop_noresp", resp_cnt - n0, 32'd0);
    check("ab_snoop_nomem", mem_acc - a0, 32'd0);

    // Master drops cyc during MEM.
    core_dly = '{-1, 1}; core_hit = '{1'b0, 1'b0};
    mem_lat = 1000;
    n0 = resp_cnt;
    start_beat(32'h0000_7000, 32'h0, 4'hF, 1'b0, 2'd0);
    tick(); tick();
    check("ab_mem_cyc_before", 32'(s_cyc_o), 32'd1);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    tick();
    check("ab_mem_cyc_drop", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    repeat (3) tick();
    check("ab_mem_noresp", resp_cnt - n0, 32'd0);

    // Asynchronous reset in the middle of a memory access.
    start_beat(32'h0000_8000, 32'h0, 4'hF, 1'b0, 2'd0);
    tick(); tick();
    check("rst_mid_cyc_before", 32'(s_cyc_o), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_s_cyc", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    check("rst_mid_resp", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
    check("rst_mid_m_dat", m_dat_o, 32'd0);
    check("rst_mid_req", 32'(snoop_req_o), 32'd0);
    check("rst_mid_s_adr", s_adr_o, 32'd0);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #2 rst_n = 1'b1;

    // Clean read after reset release.
    core_dly = '{-1, 2};
    mem_lat = 1; mem_rdat = 32'h55AA_55AA;
    run_beat(32'h0000_5008, 32'h0, 4'hF, 1'b0, 2'd0, 2'd1, 32'h55AA_55AA, 1'b1, 4);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
